// File: rtl/simt_pkg.sv
// simt_pkg: shared SIMT types and default sizing for the predicate mask stack.
package simt_pkg;

  localparam int SIMT_NUM_LANES    = 8;
  localparam int SIMT_PSTACK_DEPTH = 8;

  // One IF/ELSE nesting level: the mask that was live when the IF was
  // entered, the predicate it tested, and whether we are in the ELSE arm.
  typedef struct packed {
    logic [SIMT_NUM_LANES-1:0] parent_mask;
    logic [SIMT_NUM_LANES-1:0] cond_mask;
    logic                      inv;
  } pstack_entry_t;

  // Lanes enabled by an entry: parent lanes that take the current arm.
  function automatic logic [SIMT_NUM_LANES-1:0] pstack_entry_mask(input pstack_entry_t e);
    return e.parent_mask & (e.inv ? ~e.cond_mask : e.cond_mask);
  endfunction

endpackage

// File: rtl/pred_stack_ram.sv
// pred_stack_ram: DEPTH-entry storage for predicate stack entries.
// Masks live in a plain array (no reset, entries above the stack pointer
// are dead); inv bits are individual flops so reset can clear them and
// ELSE can flip one in place without a read-modify-write of the entry.
module pred_stack_ram
  import simt_pkg::*;
#(
  parameter int DEPTH = SIMT_PSTACK_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  pstack_entry_t wr_data_i,
  input  logic          tgl_en_i,
  input  logic [AW-1:0] tgl_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output pstack_entry_t rd_data_o
);

  logic [SIMT_NUM_LANES-1:0] parent_q [DEPTH];
  logic [SIMT_NUM_LANES-1:0] cond_q   [DEPTH];
  logic [DEPTH-1:0]          inv_q;

  // Mask write port: a push stores the parent and condition masks.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      parent_q[wr_addr_i] <= wr_data_i.parent_mask;
      cond_q[wr_addr_i]   <= wr_data_i.cond_mask;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_inv
    logic inv_bit_q;

    // Per-entry inv flag: loaded by a push, flipped by an ELSE.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        inv_bit_q <= 1'b0;
      end else if (wr_en_i && (wr_addr_i == AW'(gi))) begin
        inv_bit_q <= wr_data_i.inv;
      end else if (tgl_en_i && (tgl_addr_i == AW'(gi))) begin
        inv_bit_q <= ~inv_bit_q;
      end
    end

    assign inv_q[gi] = inv_bit_q;
  end

  // Asynchronous read of the top entry so the active mask follows the
  // stack pointer in the same cycle it changes.
  always_comb begin
    rd_data_o             = '0;
    rd_data_o.parent_mask = parent_q[rd_addr_i];
    rd_data_o.cond_mask   = cond_q[rd_addr_i];
    rd_data_o.inv         = inv_q[rd_addr_i];
  end

endmodule

// File: rtl/pred_mask_stack.sv
// pred_mask_stack: SIMT predicate register plus IF/ELSE/ENDIF mask stack.
// Optional build macro: PSTACK_ERR_FLAGS_EN builds the sticky overflow,
// underflow and cmd_err flags; without it those outputs are tied low and
// illegal commands are still silently dropped.
// Lane count follows simt_pkg::SIMT_NUM_LANES (the entry struct width).
module pred_mask_stack
  import simt_pkg::*;
#(
  parameter int NUM_LANES = SIMT_NUM_LANES,
  parameter int DEPTH     = SIMT_PSTACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       setp_we,
  input  logic [NUM_LANES-1:0]       setp_pred,
  input  logic                       pstack_push,
  input  logic                       pstack_complement,
  input  logic                       pstack_pop,
  output logic [NUM_LANES-1:0]       active_mask,
  output logic                       all_mask_true,
  output logic                       all_mask_false,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       cmd_err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0]        DEPTH_FULL = DW'(DEPTH);
  localparam logic [NUM_LANES-1:0] ALL_ONES   = '1;

  logic [DW-1:0]        depth_q, depth_d;
  logic [NUM_LANES-1:0] pred_q, pred_d;
  logic [NUM_LANES-1:0] top_parent;
  pstack_entry_t        top_entry, push_entry;
  logic [AW-1:0]        top_idx, push_idx;
  logic                 is_empty, is_full, multi_cmd;
  logic                 do_push, do_pop, do_comp;

  // Command decode: a command is dropped if it collides with another or
  // would run the stack past either end.
  always_comb begin
    is_empty  = (depth_q == '0);
    is_full   = (depth_q == DEPTH_FULL);
    multi_cmd = (pstack_push & pstack_pop) | (pstack_push & pstack_complement) |
                (pstack_pop & pstack_complement);
    do_push   = pstack_push & ~multi_cmd & ~is_full;
    do_pop    = pstack_pop & ~multi_cmd & ~is_empty;
    do_comp   = pstack_complement & ~multi_cmd & ~is_empty;
    top_idx   = AW'(depth_q - 1'b1);
    push_idx  = AW'(depth_q);
  end

  // Visible mask: everything enabled outside any IF, else the top entry.
  always_comb begin
    active_mask = ALL_ONES;
    top_parent  = ALL_ONES;
    if (!is_empty) begin
      active_mask = pstack_entry_mask(top_entry);
      top_parent  = top_entry.parent_mask;
    end
  end

  assign all_mask_false = (active_mask == '0);
  assign all_mask_true  = (active_mask == top_parent);
  assign depth          = depth_q;

  // A new entry captures the mask live before the IF and the predicate
  // held before this edge, starting in the IF (non-inverted) arm.
  always_comb begin
    push_entry             = '0;
    push_entry.parent_mask = active_mask;
    push_entry.cond_mask   = pred_q;
    push_entry.inv         = 1'b0;
  end

  pred_stack_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (do_push),
    .wr_addr_i  (push_idx),
    .wr_data_i  (push_entry),
    .tgl_en_i   (do_comp),
    .tgl_addr_i (top_idx),
    .rd_addr_i  (top_idx),
    .rd_data_o  (top_entry)
  );

  // Next stack pointer and predicate register.
  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + 1'b1;
    end else if (do_pop) begin
      depth_d = depth_q - 1'b1;
    end
    pred_d = setp_we ? setp_pred : pred_q;
  end

  // State registers; reset empties the stack immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      pred_q  <= '0;
    end else begin
      depth_q <= depth_d;
      pred_q  <= pred_d;
    end
  end

`ifdef PSTACK_ERR_FLAGS_EN
  logic overflow_q, underflow_q, cmd_err_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      if (pstack_push && !multi_cmd && is_full) begin
        overflow_q <= 1'b1;
      end
      if ((pstack_pop || pstack_complement) && !multi_cmd && is_empty) begin
        underflow_q <= 1'b1;
      end
      if (multi_cmd) begin
        cmd_err_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign cmd_err   = cmd_err_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
  assign cmd_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pred_mask_stack.sv
// tb_pred_mask_stack: directed and randomized checks of pred_mask_stack
// against a queue-based model of the IF/ELSE/ENDIF nesting rules.
`timescale 1ns/1ps
module tb_pred_mask_stack;

  localparam int L = 8;
  localparam int D = 8;
`ifdef PSTACK_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         setp_we, push, comp, pop;
  logic [L-1:0] setp_pred;
  logic [L-1:0] active_mask;
  logic         all_true, all_false;
  logic [3:0]   depth;
  logic         ovf, udf, cerr;

  always #5 clk = ~clk;

  pred_mask_stack #(.NUM_LANES(L), .DEPTH(D)) dut (
    .clk               (clk),
    .reset             (reset),
    .setp_we           (setp_we),
    .setp_pred         (setp_pred),
    .pstack_push       (push),
    .pstack_complement (comp),
    .pstack_pop        (pop),
    .active_mask       (active_mask),
    .all_mask_true     (all_true),
    .all_mask_false    (all_false),
    .depth             (depth),
    .overflow          (ovf),
    .underflow         (udf),
    .cmd_err           (cerr)
  );

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [L-1:0] parent;
    logic [L-1:0] cond;
    bit           inv;
  } ent_t;

  ent_t         stk[$];
  logic [L-1:0] m_pred;
  bit           m_ovf, m_udf, m_cerr;

  function automatic logic [L-1:0] m_mask();
    ent_t e;
    if (stk.size() == 0) return '1;
    e = stk[stk.size()-1];
    return e.inv ? (e.parent & ~e.cond) : (e.parent & e.cond);
  endfunction

  function automatic logic [L-1:0] m_parent();
    if (stk.size() == 0) return '1;
    return stk[stk.size()-1].parent;
  endfunction

  task automatic model_reset();
    stk.delete();
    m_pred = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_cerr = 1'b0;
  endtask

  task automatic model_step();
    ent_t e;
    if ($countones({push, pop, comp}) > 1) begin
      if (ERR_EN) m_cerr = 1'b1;
    end else if (push) begin
      if (stk.size() >= D) begin
        if (ERR_EN) m_ovf = 1'b1;
      end else begin
        e.parent = m_mask();
        e.cond   = m_pred;
        e.inv    = 1'b0;
        stk.push_back(e);
      end
    end else if (pop) begin
      if (stk.size() == 0) begin
        if (ERR_EN) m_udf = 1'b1;
      end else begin
        void'(stk.pop_back());
      end
    end else if (comp) begin
      if (stk.size() == 0) begin
        if (ERR_EN) m_udf = 1'b1;
      end else begin
        stk[stk.size()-1].inv = !stk[stk.size()-1].inv;
      end
    end
    if (setp_we) m_pred = setp_pred;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    #1;
    forever begin
      @(negedge clk);
      chk("active_mask", active_mask, m_mask());
      chk("all_mask_false", all_false, (m_mask() == '0));
      chk("all_mask_true", all_true, (m_mask() == m_parent()));
      chk("depth", depth, stk.size());
      chk("overflow", ovf, m_ovf);
      chk("underflow", udf, m_udf);
      chk("cmd_err", cerr, m_cerr);
    end
  end

  // One command cycle: drive after a falling edge, model the rising edge,
  // return at the next falling edge with inputs idle again.
  task automatic cyc(input bit pu, input bit po, input bit co, input bit we, input logic [L-1:0] pr);
    push = pu; pop = po; comp = co; setp_we = we; setp_pred = pr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (verbose)
      $display("cmd push=%0b pop=%0b comp=%0b we=%0b pred=%02h -> mask=%02h depth=%0d",
               pu, po, co, we, pr, active_mask, depth);
    push = 1'b0; pop = 1'b0; comp = 1'b0; setp_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1; setp_we = 1'b0; push = 1'b0; pop = 1'b0; comp = 1'b0; setp_pred = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    cyc(0, 0, 0, 0, 8'h00);
    chk("rst_mask", active_mask, 8'hFF);
    chk("rst_true", all_true, 1'b1);
    chk("rst_false", all_false, 1'b0);
    chk("rst_depth", depth, 4'd0);

    // Single IF / ELSE / ENDIF
    cyc(0, 0, 0, 1, 8'h0F);
    cyc(1, 0, 0, 0, 8'h00);
    chk("if_mask", active_mask, 8'h0F);
    chk("if_depth", depth, 4'd1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("else_mask", active_mask, 8'hF0);
    cyc(0, 1, 0, 0, 8'h00);
    chk("endif_mask", active_mask, 8'hFF);
    chk("endif_depth", depth, 4'd0);

    // Push sees the predicate from before a same-edge SETP write
    cyc(1, 0, 0, 1, 8'hAA);
    chk("same_edge_pred", active_mask, 8'h0F);
    cyc(0, 1, 0, 0, 8'h00);

    // Nested IFs
    cyc(0, 0, 0, 1, 8'h0F);
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 8'h03);
    cyc(1, 0, 0, 0, 8'h00);
    chk("nest_mask", active_mask, 8'h03);
    cyc(0, 0, 1, 0, 8'h00);
    chk("nest_else", active_mask, 8'h0C);
    cyc(0, 1, 0, 0, 8'h00);
    chk("nest_pop1", active_mask, 8'h0F);
    cyc(0, 1, 0, 0, 8'h00);
    chk("nest_pop2", active_mask, 8'hFF);

    // Empty IF arm, full ELSE arm
    cyc(0, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    chk("zero_false", all_false, 1'b1);
    chk("zero_mask", active_mask, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    chk("zero_else_mask", active_mask, 8'hFF);
    chk("zero_else_true", all_true, 1'b1);
    cyc(0, 1, 0, 0, 8'h00);

    // Overflow then underflow
    cyc(0, 0, 0, 1, 8'h0F);
    for (int i = 0; i < D; i++) cyc(1, 0, 0, 0, 8'h00);
    chk("full_depth", depth, 4'd8);
    chk("full_no_ovf", ovf, 1'b0);
    cyc(0, 0, 0, 1, 8'h01);
    cyc(1, 0, 0, 0, 8'h00);
    chk("ovf_depth", depth, 4'd8);
    chk("ovf_mask", active_mask, 8'h0F);
    chk("ovf_flag", ovf, ERR_EN);
    for (int i = 0; i < D; i++) cyc(0, 1, 0, 0, 8'h00);
    chk("drain_depth", depth, 4'd0);
    cyc(0, 1, 0, 0, 8'h00);
    chk("udf_flag", udf, ERR_EN);
    chk("udf_mask", active_mask, 8'hFF);
    chk("ovf_sticky", ovf, ERR_EN);

    // Reset clears sticky flags
    do_reset();
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_udf", udf, 1'b0);

    // Colliding commands at depth 2, then asynchronous reset mid-cycle
    cyc(0, 0, 0, 1, 8'h0F);
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 8'h00);
    chk("collide_depth", depth, 4'd2);
    chk("collide_err", cerr, ERR_EN);
    chk("collide_mask", active_mask, 8'h0F);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_depth", depth, 4'd0);
    chk("async_mask", active_mask, 8'hFF);
    chk("async_err", cerr, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    verbose = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 30)       cyc(1, 0, 0, $urandom_range(0, 1) == 1, L'($urandom));
        else if (r < 55)  cyc(0, 1, 0, $urandom_range(0, 1) == 1, L'($urandom));
        else if (r < 75)  cyc(0, 0, 1, $urandom_range(0, 1) == 1, L'($urandom));
        else if (r < 80)  cyc(1, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1, L'($urandom));
        else              cyc(0, 0, 0, $urandom_range(0, 1) == 1, L'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pred_mask_stack.md
PRED_MASK_STACK -- requirements
Module: pred_mask_stack

Interface
REQ-001 Parameter NUM_LANES, default 8, SHALL set the number of SIMT lanes (mask width).
REQ-002 Parameter DEPTH, default 8, SHALL set the maximum IF/ELSE nesting depth (stack entries).
REQ-003 clk  input  1  SHALL be the clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 setp_we  input  1  SHALL write setp_pred into the predicate register.
REQ-006 setp_pred  input  NUM_LANES  SHALL carry the per-lane SETP compare result.
REQ-007 pstack_push  input  1  SHALL be the IF_P command from the control unit.
REQ-008 pstack_complement  input  1  SHALL be the ELSE_P command.
REQ-009 pstack_pop  input  1  SHALL be the ENDIF command.
REQ-010 active_mask  output  NUM_LANES  SHALL give the lanes currently enabled for register writes.
REQ-011 all_mask_true  output  1  SHALL flag that every parent-enabled lane is active.
REQ-012 all_mask_false  output  1  SHALL flag that no lane is active.
REQ-013 depth  output  $clog2(DEPTH+1)  SHALL give the current stack occupancy.
REQ-014 overflow, underflow, cmd_err  output  1 each  SHALL be sticky error flags.

Function
REQ-015 Each entry SHALL hold {parent_mask, cond_mask, inv}; the top entry is index depth-1.
REQ-016 With depth==0, active_mask SHALL be all ones; otherwise it SHALL be parent & (inv ? ~cond : cond) of the top entry.
REQ-017 all_mask_false SHALL equal (active_mask==0); all_mask_true SHALL equal (active_mask==parent of top entry, or all ones at depth 0); both combinational from registered state.
REQ-018 Push SHALL write {active_mask, pred_reg, 0} at index depth and increment depth; the new mask is visible the next cycle.
REQ-019 Complement SHALL toggle inv of the top entry; depth unchanged.
REQ-020 Pop SHALL decrement depth, restoring the previous active_mask the next cycle.
REQ-021 Push SHALL use the pred_reg value held before the edge; setp_we on the same edge updates pred_reg for later commands only.
REQ-022 Push at depth==DEPTH SHALL be ignored and set overflow.
REQ-023 Pop or complement at depth==0 SHALL be ignored and set underflow.
REQ-024 More than one of push/pop/complement in one cycle SHALL be ignored entirely and set cmd_err.
REQ-025 Each command SHALL take effect in exactly one cycle; no stall or handshake.

Reset
REQ-026 Reset SHALL force depth=0, pred_reg=0, all inv bits=0, flags=0; active_mask=all ones, all_mask_true=1, all_mask_false=0.
REQ-027 Reset asserted mid-nesting SHALL discard all entries immediately (asynchronous).
REQ-028 Error flags SHALL clear only on reset.

Configuration
REQ-029 With PSTACK_ERR_FLAGS_EN defined, overflow/underflow/cmd_err SHALL behave as REQ-022..024.
REQ-030 Without PSTACK_ERR_FLAGS_EN, the three flags SHALL be tied to 0, illegal commands are still ignored, and no flag registers are built.

Structure
REQ-031 Shared package simt_pkg SHALL hold the pstack_entry_t struct typedef and the default NUM_LANES/DEPTH constants.
REQ-032 Entry storage SHALL be a sub-module pred_stack_ram (DEPTH x entry, one write port, one read port at the top index, plus an inv-toggle port).

Verification
REQ-033 Reset, no commands -> active_mask=8'hFF, all_mask_true=1, all_mask_false=0, depth=0.
REQ-034 setp_pred=8'h0F with setp_we, then push -> active_mask=8'h0F, depth=1; complement -> 8'hF0; pop -> 8'hFF, depth=0.
REQ-035 Nested: pred 8'h0F push, pred 8'h03 push -> 8'h03; complement -> 8'h0C; pop -> 8'h0F; pop -> 8'hFF.
REQ-036 pred 8'h00 push -> all_mask_false=1; complement -> active_mask=8'hFF, all_mask_true=1.
REQ-037 DEPTH+1 pushes -> depth=8, overflow=1, mask unchanged by the last push; pop at depth 0 -> underflow=1.
REQ-038 Push and pop in the same cycle at depth 2 -> depth stays 2, cmd_err=1; reset mid-sequence -> depth=0, flags cleared.
